i2s_tx_serializer: RTL and testbench
====================================

I2S_TX_SERIALIZER -- requirements
Module: i2s_tx_serializer

Interface
REQ-001 Parameter DATA_W, default 16: sample width in bits, range 8..32.
REQ-002 Parameter SLOT_W, default 16: BCK periods per channel slot; SLOT_W >= DATA_W, range 16..32.
REQ-003 Parameter BCK_DIV, default 1: clk cycles per BCK half-period, range >= 1.
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port left_i, input, DATA_W: signed left-channel sample.
REQ-007 Port right_i, input, DATA_W: signed right-channel sample.
REQ-008 Port valid_i, input, 1: left_i/right_i pair offered.
REQ-009 Port ready_o, input-side output, 1: holding buffer empty; the pair transfers when valid_i && ready_o.
REQ-010 Port mode_i, input, 2: 00 I2S, 01 left-justified, 10 right-justified, 11 treated as I2S.
REQ-011 Port BCK_o, output, 1: bit clock, registered.
REQ-012 Port WS_o, output, 1: word select, registered.
REQ-013 Port DIN_o, output, 1: serial data, MSB first, registered.
REQ-014 Port underrun_o, output, 1: one-clk pulse at a frame start with the buffer empty.

Function
REQ-015 BCK_o shall toggle every BCK_DIV clk cycles; a falling BCK_o toggle is a bit boundary.
REQ-016 At each bit boundary, the following shall update in the same clk edge as BCK_o falls: bit_cnt (0..2*SLOT_W-1, wrapping), WS_o, and DIN_o.
REQ-017 bit_cnt wrapping to 0 is a frame start.
REQ-018 At frame start, mode_i shall be sampled and held for the whole frame.
REQ-019 At frame start, the buffered pair shall load into the 2*SLOT_W frame shift register, and the buffer shall empty.
REQ-020 The frame-start consume shall see buffer state before any same-cycle write; a pair written in that cycle waits for the next frame.
REQ-021 ready_o shall equal !buffer_full, combinationally.
REQ-022 Slot layout, left-justified and I2S: sample in the top DATA_W bits, zeros below.
REQ-023 Slot layout, right-justified: sample sign-extended to SLOT_W.
REQ-024 Left slot = bit_cnt 0..SLOT_W-1; right slot = bit_cnt SLOT_W..2*SLOT_W-1.
REQ-025 WS_o, I2S: 0 for bit_cnt 0..SLOT_W-1, 1 otherwise.
REQ-026 WS_o, left-/right-justified: 1 for the left slot, 0 for the right slot.
REQ-027 I2S data shall lag WS_o by one bit: DIN_o at bit_cnt 0 is the previous frame's right LSB, held in a 1-bit carry register.
REQ-028 Left MSB, I2S: driven at bit_cnt 1.
REQ-029 Left MSB, left-/right-justified: driven at bit_cnt 0.
REQ-030 A mode change shall take effect only at frame start; the I2S carry bit shall be emitted regardless of the new mode.
REQ-031 Underrun without the configuration macro: the frame shall transmit all zeros, and underrun_o shall pulse for 1 clk.

Reset
REQ-032 While rst_n = 0, the following shall be 0: BCK_o, WS_o, DIN_o, underrun_o, the carry register, the divider count, and buffer_full.
REQ-033 During reset, bit_cnt shall be 2*SLOT_W-1, so the first bit boundary, 2*BCK_DIV clk cycles after release, is a frame start.
REQ-034 Reset mid-frame shall abort the frame immediately and discard any buffered pair; no partial frame resumes.

Configuration
REQ-035 Macro I2S_TX_UNDERRUN_REPEAT_EN defined: on underrun, the last successfully loaded pair (zeros if none since reset) shall be retransmitted, and underrun_o shall still pulse.
REQ-036 Macro I2S_TX_UNDERRUN_REPEAT_EN undefined: zero-fill per REQ-031, and no last-pair storage is built.

Structure
REQ-037 Package i2s_tx_pkg shall hold the mode encodings (MODE_I2S, MODE_LJ, MODE_RJ) and the parameter range limits.
REQ-038 Sub-module i2s_bck_gen shall contain the BCK divider, producing BCK_o and a one-clk bit-boundary strobe.

Verification
REQ-039 DATA_W=16, SLOT_W=16, BCK_DIV=1, I2S; pair L=16'h8001, R=16'h7FFE presented before the first frame -> WS_o low for 16 bits; DIN_o = 0, then 1000_0000_0000_0001, then 0111_1111_1111_1110 with its LSB at the next frame's bit 0.
REQ-040 Left-justified, SLOT_W=32, DATA_W=24, L=24'hABCDEF -> left slot = ABCDEF then 8 zeros; WS_o high for the left slot.
REQ-041 Right-justified, SLOT_W=32, DATA_W=16, L=16'hF000 -> left slot = 16'hFFFF then 16'hF000.
REQ-042 No valid_i for one frame -> underrun_o pulses once at frame start; DIN_o is all zeros (macro undefined) or the previous pair (macro defined).
REQ-043 valid_i asserted on the frame-start cycle with the buffer empty -> underrun for that frame; the pair is sent next frame; ready_o low until then.
REQ-044 BCK_DIV=3; rst_n pulsed low mid-frame -> all outputs 0 asynchronously; first BCK_o fall 6 clk after release, starting a new frame.

Source files
------------

// File: rtl/i2s_tx_pkg.sv
// Shared constants for the I2S transmit serializer: mode encodings and parameter limits.
package i2s_tx_pkg;

   localparam logic [1:0] MODE_I2S = 2'b00;
   localparam logic [1:0] MODE_LJ  = 2'b01;
   localparam logic [1:0] MODE_RJ  = 2'b10;

   localparam int DATA_W_MIN  = 8;
   localparam int DATA_W_MAX  = 32;
   localparam int SLOT_W_MIN  = 16;
   localparam int SLOT_W_MAX  = 32;
   localparam int BCK_DIV_MIN = 1;

endpackage

// File: rtl/i2s_bck_gen.sv
// Bit-clock divider: BCK_o toggles every BCK_DIV clk cycles; bit_stb_o marks the
// clk edge on which BCK_o falls (the serializer's bit boundary).
module i2s_bck_gen #(
   parameter int BCK_DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   output logic bck_o,
   output logic bit_stb_o
);

   localparam int CW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;

   logic [CW-1:0] div_cnt;
   logic          terminal;

   assign terminal  = (div_cnt == CW'(BCK_DIV - 1));
   assign bit_stb_o = terminal && bck_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         bck_o   <= 1'b0;
      end else if (terminal) begin
         div_cnt <= '0;
         bck_o   <= ~bck_o;
      end else begin
         div_cnt <= div_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S / left-justified / right-justified stereo serializer with a one-pair holding buffer.
// Define I2S_TX_UNDERRUN_REPEAT_EN to retransmit the last loaded pair on underrun instead of zeros.
module i2s_tx_serializer
   import i2s_tx_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int SLOT_W  = 16,
   parameter int BCK_DIV = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [DATA_W-1:0] left_i,
   input  logic signed [DATA_W-1:0] right_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   input  logic [1:0]               mode_i,
   output logic                     BCK_o,
   output logic                     WS_o,
   output logic                     DIN_o,
   output logic                     underrun_o
);

   localparam int                FRAME_W  = 2 * SLOT_W;
   localparam int                CNT_W    = $clog2(FRAME_W);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_W - 1);

   logic                     bit_stb;
   logic                     frame_start;
   logic                     wr_en;
   logic                     buffer_full;
   logic                     carry;
   logic [CNT_W-1:0]         bit_cnt;
   logic [CNT_W-1:0]         cnt_nxt;
   logic [1:0]               mode_q;
   logic [1:0]               mode_cur;
   logic signed [DATA_W-1:0] buf_l;
   logic signed [DATA_W-1:0] buf_r;
   logic signed [DATA_W-1:0] src_l;
   logic signed [DATA_W-1:0] src_r;
   logic [FRAME_W-1:0]       frame_word;
   logic [FRAME_W-1:0]       frame_sr;

   function automatic logic is_i2s(input logic [1:0] m);
      return (m != MODE_LJ) && (m != MODE_RJ);
   endfunction

   // Right-justified sign-extends into the slot; the other modes left-align with zero fill.
   function automatic logic [SLOT_W-1:0] fmt_slot(input logic signed [DATA_W-1:0] s,
                                                  input logic [1:0] m);
      logic signed [SLOT_W-1:0] ext;
      ext = {{(SLOT_W - DATA_W + 1){s[DATA_W-1]}}, s[DATA_W-2:0]};
      if (m == MODE_RJ) return ext;
      return ext << (SLOT_W - DATA_W);
   endfunction

   i2s_bck_gen #(.BCK_DIV(BCK_DIV)) u_bck_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .bck_o     (BCK_o),
      .bit_stb_o (bit_stb)
   );

   assign ready_o     = !buffer_full;
   assign wr_en       = valid_i && ready_o;
   assign frame_start = bit_stb && (bit_cnt == LAST_CNT);
   assign cnt_nxt     = (bit_cnt == LAST_CNT) ? '0 : bit_cnt + CNT_W'(1);
   assign mode_cur    = frame_start ? mode_i : mode_q;

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
   logic signed [DATA_W-1:0] last_l;
   logic signed [DATA_W-1:0] last_r;

   assign src_l = buffer_full ? buf_l : last_l;
   assign src_r = buffer_full ? buf_r : last_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_l <= '0;
         last_r <= '0;
      end else if (frame_start && buffer_full) begin
         last_l <= buf_l;
         last_r <= buf_r;
      end
   end
`else
   assign src_l = buffer_full ? buf_l : '0;
   assign src_r = buffer_full ? buf_r : '0;
`endif

   assign frame_word = {fmt_slot(src_l, mode_i), fmt_slot(src_r, mode_i)};

   // Control: bit counter, buffer flag, mode latch and registered serial outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt     <= LAST_CNT;
         buffer_full <= 1'b0;
         mode_q      <= MODE_I2S;
         carry       <= 1'b0;
         WS_o        <= 1'b0;
         DIN_o       <= 1'b0;
         underrun_o  <= 1'b0;
      end else begin
         underrun_o <= frame_start && !buffer_full;
         if (wr_en)            buffer_full <= 1'b1;
         else if (frame_start) buffer_full <= 1'b0;
         if (bit_stb) begin
            bit_cnt <= cnt_nxt;
            WS_o    <= is_i2s(mode_cur) ? (cnt_nxt >= CNT_W'(SLOT_W))
                                        : (cnt_nxt <  CNT_W'(SLOT_W));
            if (frame_start) begin
               mode_q <= mode_i;
               carry  <= frame_word[0];
               DIN_o  <= is_i2s(mode_i) ? carry : frame_word[FRAME_W-1];
            end else begin
               DIN_o  <= frame_sr[FRAME_W-1];
            end
         end
      end
   end

   // Data: holding buffer and frame shift register (I2S keeps the MSB for the one-bit lag).
   always_ff @(posedge clk) begin
      if (wr_en) begin
         buf_l <= left_i;
         buf_r <= right_i;
      end
      if (frame_start)  frame_sr <= is_i2s(mode_i) ? frame_word : (frame_word << 1);
      else if (bit_stb) frame_sr <= frame_sr << 1;
   end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: two instances (16/16/1 and 24/32/3) checked frame by frame
// against a slot-layout reference model; honours I2S_TX_UNDERRUN_REPEAT_EN when defined.
module tb_i2s_tx_serializer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  mode_s  [2];
   logic        valid_s [2];
   logic [31:0] l_s     [2];
   logic [31:0] r_s     [2];
   logic        bck_w [2];
   logic        ws_w  [2];
   logic        din_w [2];
   logic        und_w [2];
   logic        rdy_w [2];

   int n_checks = 0;
   int n_fail   = 0;

   // reference-model state per instance
   logic        pend_full [2];
   logic [31:0] pend_l [2];
   logic [31:0] pend_r [2];
   logic [31:0] last_l [2];
   logic [31:0] last_r [2];
   logic        carry_m [2];

   always #5 clk = ~clk;

   i2s_tx_serializer #(.DATA_W(16), .SLOT_W(16), .BCK_DIV(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .left_i(l_s[0][15:0]), .right_i(r_s[0][15:0]),
      .valid_i(valid_s[0]), .ready_o(rdy_w[0]), .mode_i(mode_s[0]), .BCK_o(bck_w[0]),
      .WS_o(ws_w[0]), .DIN_o(din_w[0]), .underrun_o(und_w[0]));

   i2s_tx_serializer #(.DATA_W(24), .SLOT_W(32), .BCK_DIV(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .left_i(l_s[1][23:0]), .right_i(r_s[1][23:0]),
      .valid_i(valid_s[1]), .ready_o(rdy_w[1]), .mode_i(mode_s[1]), .BCK_o(bck_w[1]),
      .WS_o(ws_w[1]), .DIN_o(din_w[1]), .underrun_o(und_w[1]));

   function automatic int dw_of(int w);  return (w != 0) ? 24 : 16; endfunction
   function automatic int sw_of(int w);  return (w != 0) ? 32 : 16; endfunction
   function automatic int div_of(int w); return (w != 0) ? 3 : 1;   endfunction

   function automatic logic i2s_mode(logic [1:0] m);
      return (m == 2'b00) || (m == 2'b11);
   endfunction

   // Slot contents as an integer: sign-extended for right-justified, left-aligned otherwise.
   function automatic logic [63:0] slot_val(int dw, int sw, logic [1:0] m, logic [31:0] x);
      logic [63:0] v;
      logic [63:0] dmask;
      dmask = (64'd1 << dw) - 64'd1;
      v = {32'd0, x} & dmask;
      if (m == 2'b10) begin
         if (v[dw-1]) v = v | ~dmask;
         v = v & ((64'd1 << sw) - 64'd1);
      end else begin
         v = v << (sw - dw);
      end
      return v;
   endfunction

   task automatic model_reset();
      for (int w = 0; w < 2; w++) begin
         pend_full[w] = 1'b0;
         pend_l[w] = '0; pend_r[w] = '0;
         last_l[w] = '0; last_r[w] = '0;
         carry_m[w] = 1'b0;
         valid_s[w] = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      valid_s[0] = 1'b0;
      valid_s[1] = 1'b0;
      repeat (3) @(negedge clk);
      model_reset();
      rst_n = 1'b1;
   endtask

   // Present a pair right now; it is written on the next rising edge.
   task automatic offer_now(input int w, input logic [31:0] l, input logic [31:0] r);
      n_checks++;
      if (rdy_w[w] !== 1'b1) begin
         n_fail++;
         $display("FAIL offer_ready dut%0d: ready_o=%b required 1", w, rdy_w[w]);
      end
      l_s[w] = l; r_s[w] = r; valid_s[w] = 1'b1;
      pend_l[w] = l; pend_r[w] = r; pend_full[w] = 1'b1;
   endtask

   // Capture one full frame and compare it with the model.
   // offer: 0 none, 1 new pair after the frame-start consume, 2 new pair on the frame-start cycle.
   task automatic run_frame(input int w, input int offer, input logic [31:0] nl,
                            input logic [31:0] nr, input logic [1:0] m, output int first_cyc);
      int dw, sw, div, cyc, k, ucnt, limit;
      logic prev, rdy_mid, exp_und, old_carry;
      logic [31:0] sl, sr;
      logic [63:0] dv, wv, fw, ev, ewv;
      dw = dw_of(w); sw = sw_of(w); div = div_of(w);
      mode_s[w] = m;
      if (pend_full[w]) begin
         sl = pend_l[w]; sr = pend_r[w];
         last_l[w] = sl; last_r[w] = sr;
         pend_full[w] = 1'b0; exp_und = 1'b0;
      end else begin
         exp_und = 1'b1;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
         sl = last_l[w]; sr = last_r[w];
`else
         sl = '0; sr = '0;
`endif
      end
      fw = (slot_val(dw, sw, m, sl) << sw) | slot_val(dw, sw, m, sr);
      old_carry = carry_m[w];
      carry_m[w] = fw[0];
      ev = '0; ewv = '0;
      for (int i = 0; i < 2 * sw; i++) begin
         if (i2s_mode(m)) begin
            ev[i]  = (i == 0) ? old_carry : fw[2*sw-i];
            ewv[i] = (i >= sw);
         end else begin
            ev[i]  = fw[2*sw-1-i];
            ewv[i] = (i < sw);
         end
      end
      if (offer != 0) begin
         pend_l[w] = nl; pend_r[w] = nr; pend_full[w] = 1'b1;
      end
      dv = '0; wv = '0; cyc = 0; k = 0; ucnt = 0; first_cyc = -1; rdy_mid = 1'bx;
      limit = 4 * sw * div + 4 * div + 8;
      prev = bck_w[w];
      while (k < 2 * sw && cyc < limit) begin
         @(negedge clk);
         cyc++;
         if (valid_s[w]) valid_s[w] = 1'b0;
         if (und_w[w]) ucnt++;
         if (prev && !bck_w[w]) begin
            dv[k] = din_w[w]; wv[k] = ws_w[w];
            if (k == 0) first_cyc = cyc;
            if (k == 2) rdy_mid = rdy_w[w];
            k++;
            if (k == 1 && offer == 1) begin
               l_s[w] = nl; r_s[w] = nr; valid_s[w] = 1'b1;
            end
         end
         prev = bck_w[w];
         if (offer == 2 && cyc == 2 * div - 1) begin
            l_s[w] = nl; r_s[w] = nr; valid_s[w] = 1'b1;
         end
      end
      n_checks++;
      if (k < 2 * sw) begin
         n_fail++;
         $display("FAIL frame_timeout dut%0d: %0d bit boundaries seen, %0d required", w, k, 2 * sw);
      end
      n_checks++;
      if (dv !== ev) begin
         n_fail++;
         $display("FAIL din_bits dut%0d mode%0d: got %h want %h (bit k at position k)", w, m, dv, ev);
      end
      n_checks++;
      if (wv !== ewv) begin
         n_fail++;
         $display("FAIL ws_bits dut%0d mode%0d: got %h want %h", w, m, wv, ewv);
      end
      n_checks++;
      if (ucnt !== (exp_und ? 1 : 0)) begin
         n_fail++;
         $display("FAIL underrun_pulses dut%0d: got %0d want %0d", w, ucnt, exp_und ? 1 : 0);
      end
      n_checks++;
      if (rdy_mid !== (offer == 0)) begin
         n_fail++;
         $display("FAIL ready_mid_frame dut%0d: got %b want %b", w, rdy_mid, offer == 0);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      for (int w = 0; w < 2; w++) begin
         n_checks++;
         if ({bck_w[w], ws_w[w], din_w[w], und_w[w]} !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s dut%0d: BCK/WS/DIN/UND=%b%b%b%b required 0000", tag, w,
                     bck_w[w], ws_w[w], din_w[w], und_w[w]);
         end
         n_checks++;
         if (rdy_w[w] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready dut%0d: got %b want 1", tag, w, rdy_w[w]);
         end
      end
   endtask

   task automatic test_reset();
      int fc;
      @(negedge clk);
      check_idle_outputs("reset_state");
      do_reset();
      check_idle_outputs("reset_release");
      run_frame(0, 0, '0, '0, 2'b00, fc);
      n_checks++;
      if (fc !== 2) begin
         n_fail++;
         $display("FAIL first_boundary dut0: got %0d clk want 2", fc);
      end
   endtask

   task automatic test_i2s_vector();
      int fc;
      do_reset();
      offer_now(0, 32'h8001, 32'h7FFE);
      run_frame(0, 1, 32'h00A5, 32'h0001, 2'b00, fc);
      run_frame(0, 0, '0, '0, 2'b00, fc);
      run_frame(0, 0, '0, '0, 2'b00, fc);
   endtask

   task automatic test_random_modes();
      int fc;
      for (int m = 0; m < 4; m++) begin
         do_reset();
         offer_now(0, $urandom, $urandom);
         for (int f = 0; f < 4; f++) run_frame(0, 1, $urandom, $urandom, 2'(m), fc);
         run_frame(0, 0, '0, '0, 2'(m), fc);
      end
   endtask

   task automatic test_wide_lj_rj();
      int fc;
      do_reset();
      offer_now(1, 32'h00AB_CDEF, $urandom);
      run_frame(1, 1, 32'h0080_F000, 32'h0000_1234, 2'b01, fc);
      run_frame(1, 1, $urandom, $urandom, 2'b10, fc);
      run_frame(1, 0, '0, '0, 2'b00, fc);
   endtask

   task automatic test_underrun();
      int fc;
      do_reset();
      offer_now(0, $urandom, $urandom | 32'h1);
      run_frame(0, 0, '0, '0, 2'b00, fc);
      run_frame(0, 0, '0, '0, 2'b00, fc);
      run_frame(0, 1, $urandom, $urandom, 2'b01, fc);
      run_frame(0, 0, '0, '0, 2'b01, fc);
   endtask

   task automatic test_offer_at_frame_start();
      int fc;
      do_reset();
      offer_now(0, $urandom, $urandom);
      run_frame(0, 0, '0, '0, 2'b01, fc);
      run_frame(0, 2, 32'h0000_C3A5, 32'h0000_5A3C, 2'b01, fc);
      run_frame(0, 0, '0, '0, 2'b01, fc);
   endtask

   task automatic test_reset_mid_frame();
      int fc, n;
      do_reset();
      offer_now(1, $urandom, $urandom);
      run_frame(1, 1, $urandom, $urandom, 2'b00, fc);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bck_w[1] !== 1'b1 && n < 20);
      #2 rst_n = 1'b0;
      #1 check_idle_outputs("async_reset");
      repeat (2) @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      run_frame(1, 0, '0, '0, 2'b01, fc);
      n_checks++;
      if (fc !== 6) begin
         n_fail++;
         $display("FAIL first_boundary dut1: got %0d clk want 6", fc);
      end
   endtask

   initial begin
      model_reset();
      for (int w = 0; w < 2; w++) begin
         mode_s[w] = 2'b00; l_s[w] = '0; r_s[w] = '0;
      end
      test_reset();
      test_i2s_vector();
      test_random_modes();
      test_wide_lj_rj();
      test_underrun();
      test_offer_at_frame_start();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
